wait_state_controller: RTL and testbench

- Sequences the 8088 bus cycle from processor status and produces the registered READY for the CPU.
- Inserts a fixed number of wait states per cycle type, then holds READY low while peripheral_ready is low.
- A watchdog forces READY high if a peripheral never responds.
- Sits between the CPU status decode and the CPU READY pin. Its peripheral_ready input is the AND of the video, sound and expansion readies.

---
 rtl/pcjr_bus_pkg.sv | 32 +++
 rtl/bus_cycle_decoder.sv | 45 ++++
 rtl/wait_state_controller.sv | 188 ++++++++++++++++++
 tb/tb_wait_state_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcjr_bus_pkg.sv
// Shared bus definitions for the 8088 bus-cycle logic: status codes,
// cycle classification and the bus-cycle sequencer states.
package pcjr_bus_pkg;

    // S2..S0 as driven by the 8088
    typedef enum logic [2:0] {
        ST_INTA    = 3'b000,
        ST_IOR     = 3'b001,
        ST_IOW     = 3'b010,
        ST_HALT    = 3'b011,
        ST_FETCH   = 3'b100,
        ST_MEMR    = 3'b101,
        ST_MEMW    = 3'b110,
        ST_PASSIVE = 3'b111
    } bus_status_t;

    typedef enum logic [1:0] {
        CYC_NONE = 2'b00,
        CYC_MEM  = 2'b01,
        CYC_IO   = 2'b10,
        CYC_INTA = 2'b11
    } cycle_type_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4
    } fsm_state_t;

endpackage

// File: rtl/bus_cycle_decoder.sv
// Classifies a CPU status code into a cycle type and the number of wait
// states that cycle needs. HALT and passive codes are not bus cycles.
module bus_cycle_decoder
    import pcjr_bus_pkg::*;
#(
    parameter int MEM_WAITS  = 0,
    parameter int IO_WAITS   = 1,
    parameter int INTA_WAITS = 1,
    parameter int CNT_WIDTH  = 3
) (
    input  logic [2:0]           status,
    input  logic                 mem_wait_enable,
    output cycle_type_t          cycle_type,
    output logic [CNT_WIDTH-1:0] wait_count
);

    localparam logic [CNT_WIDTH-1:0] MEM_N  = CNT_WIDTH'(MEM_WAITS);
    localparam logic [CNT_WIDTH-1:0] IO_N   = CNT_WIDTH'(IO_WAITS);
    localparam logic [CNT_WIDTH-1:0] INTA_N = CNT_WIDTH'(INTA_WAITS);

    // Status code to cycle type and wait count
    always_comb begin
        cycle_type = CYC_NONE;
        wait_count = '0;
        case (bus_status_t'(status))
            ST_INTA: begin
                cycle_type = CYC_INTA;
                wait_count = INTA_N;
            end
            ST_IOR, ST_IOW: begin
                cycle_type = CYC_IO;
                wait_count = IO_N;
            end
            ST_FETCH, ST_MEMR, ST_MEMW: begin
                cycle_type = CYC_MEM;
                wait_count = mem_wait_enable ? MEM_N : '0;
            end
            default: begin
                cycle_type = CYC_NONE;
                wait_count = '0;
            end
        endcase
    end

endmodule

// File: rtl/wait_state_controller.sv
// Sequences the 8088 bus cycle (IDLE/T1/T2/TW/T3) from the CPU status lines
// and drives the registered READY. Waits are a fixed count per cycle type,
// extended while peripheral_ready is low, and bounded by a watchdog.
module wait_state_controller
    import pcjr_bus_pkg::*;
#(
    parameter int MEM_WAITS  = 0,
    parameter int IO_WAITS   = 1,
    parameter int INTA_WAITS = 1,
    parameter int CNT_WIDTH  = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_clock_posedge,
    input  logic       cpu_clock_negedge,
    input  logic [2:0] processor_status,
    input  logic       mem_wait_enable,
    input  logic       peripheral_ready,
    input  logic       timeout_clear,
    output logic       ready,
    output logic [1:0] cycle_type,
    output logic       wait_active,
    output logic       timeout_error
);

    localparam int TMO_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [TMO_WIDTH-1:0] TMO_LIMIT = TMO_WIDTH'(TIMEOUT);

    function automatic logic [CNT_WIDTH-1:0] wait_dec(input logic [CNT_WIDTH-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    function automatic logic [TMO_WIDTH-1:0] tmo_inc(input logic [TMO_WIDTH-1:0] v);
        return (v == TMO_LIMIT) ? v : v + 1'b1;
    endfunction

    fsm_state_t           state_q, state_d;
    bus_status_t          prev_status_q, prev_status_d;
    cycle_type_t          cycle_type_q, cycle_type_d;
    logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [TMO_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                 ready_q, ready_d;
    logic                 timeout_error_q, timeout_error_d;

    bus_status_t          status_now;
    logic                 status_passive;
    logic                 tmo_hit;
    logic [TMO_WIDTH-1:0] tmo_next;
    cycle_type_t          dec_type;
    logic [CNT_WIDTH-1:0] dec_waits;

    assign status_now     = bus_status_t'(processor_status);
    assign status_passive = (status_now == ST_PASSIVE);
    assign tmo_next       = tmo_inc(tmo_cnt_q);

    bus_cycle_decoder #(
        .MEM_WAITS  (MEM_WAITS),
        .IO_WAITS   (IO_WAITS),
        .INTA_WAITS (INTA_WAITS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_decoder (
        .status          (processor_status),
        .mem_wait_enable (mem_wait_enable),
        .cycle_type      (dec_type),
        .wait_count      (dec_waits)
    );

    // Bus-cycle sequencing and counters, advanced on the CPU clock rising edge
    always_comb begin
        state_d       = state_q;
        prev_status_d = prev_status_q;
        cycle_type_d  = cycle_type_q;
        wait_cnt_d    = wait_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        tmo_hit       = 1'b0;
        if (cpu_clock_posedge) begin
            prev_status_d = status_now;
            unique case (state_q)
                S_IDLE: begin
                    // Only a passive-to-active edge starts a cycle; HALT decodes as NONE.
                    // The wait count is captured here so it reflects T1 conditions.
                    if (prev_status_q == ST_PASSIVE && dec_type != CYC_NONE) begin
                        state_d      = S_T1;
                        cycle_type_d = dec_type;
                        wait_cnt_d   = dec_waits;
                    end
                end
                S_T1: begin
                    if (status_passive) begin
                        state_d      = S_IDLE;
                        cycle_type_d = CYC_NONE;
                    end else begin
                        state_d   = S_T2;
                        tmo_cnt_d = '0;
                    end
                end
                S_T2: begin
                    if (status_passive) begin
                        state_d      = S_IDLE;
                        cycle_type_d = CYC_NONE;
                    end else if (wait_cnt_q != '0 || !peripheral_ready) begin
                        // Entering TW consumes the first wait so READY can rise
                        // at the negedge of the last TW.
                        state_d    = S_TW;
                        wait_cnt_d = wait_dec(wait_cnt_q);
                    end else begin
                        state_d = S_T3;
                    end
                end
                S_TW: begin
                    if (status_passive) begin
                        state_d      = S_IDLE;
                        cycle_type_d = CYC_NONE;
                    end else begin
                        tmo_cnt_d  = tmo_next;
                        wait_cnt_d = wait_dec(wait_cnt_q);
                        if (tmo_next == TMO_LIMIT) begin
                            tmo_hit = 1'b1;
                            state_d = S_T3;
                        end else if (wait_cnt_q == '0 && peripheral_ready) begin
                            state_d = S_T3;
                        end
                    end
                end
                S_T3: begin
                    // T3 also stands in for T4 until the CPU goes passive
                    if (status_passive) begin
                        state_d      = S_IDLE;
                        cycle_type_d = CYC_NONE;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    cycle_type_d = CYC_NONE;
                end
            endcase
        end
    end

    // READY update on the CPU clock falling edge, using post-posedge state so a
    // coincident rising edge is seen first. A watchdog expiry leaves TW in the
    // same clock, so the forced-high case falls out of the state test.
    always_comb begin
        ready_d = ready_q;
        if (cpu_clock_negedge) begin
            ready_d = !(((state_d == S_T2) || (state_d == S_TW)) &&
                        ((wait_cnt_d != '0) || !peripheral_ready));
        end
    end

    // Sticky watchdog flag; a new expiry beats a simultaneous clear
    always_comb begin
        timeout_error_d = timeout_error_q;
        if (tmo_hit) begin
            timeout_error_d = 1'b1;
        end else if (timeout_clear) begin
            timeout_error_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            prev_status_q   <= ST_INTA;
            cycle_type_q    <= CYC_NONE;
            wait_cnt_q      <= '0;
            tmo_cnt_q       <= '0;
            ready_q         <= 1'b1;
            timeout_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            prev_status_q   <= prev_status_d;
            cycle_type_q    <= cycle_type_d;
            wait_cnt_q      <= wait_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            ready_q         <= ready_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    assign ready         = ready_q;
    assign cycle_type    = cycle_type_q;
    assign wait_active   = (state_q == S_TW);
    assign timeout_error = timeout_error_q;

endmodule

// File: tb/tb_wait_state_controller.sv
`timescale 1ns/1ps
// Bench for wait_state_controller: a table of complete bus cycles plus
// hand-built sequences for HALT, strobe coincidence, abort, watchdog and reset.
module tb_wait_state_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_clock_posedge = 1'b0;
    logic       cpu_clock_negedge = 1'b0;
    logic [2:0] processor_status = 3'b111;
    logic       mem_wait_enable = 1'b0;
    logic       peripheral_ready = 1'b1;
    logic       timeout_clear = 1'b0;
    logic       ready;
    logic [1:0] cycle_type;
    logic       wait_active;
    logic       timeout_error;

    always #5 clock = ~clock;

    wait_state_controller #(
        .MEM_WAITS  (2),
        .IO_WAITS   (1),
        .INTA_WAITS (1),
        .CNT_WIDTH  (3),
        .TIMEOUT    (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_clock_posedge (cpu_clock_posedge),
        .cpu_clock_negedge (cpu_clock_negedge),
        .processor_status  (processor_status),
        .mem_wait_enable   (mem_wait_enable),
        .peripheral_ready  (peripheral_ready),
        .timeout_clear     (timeout_clear),
        .ready             (ready),
        .cycle_type        (cycle_type),
        .wait_active       (wait_active),
        .timeout_error     (timeout_error)
    );

    typedef struct {
        logic [2:0] status;
        logic       mwe;
        int         lowp;     // CPU periods (from T2) with peripheral_ready low
        int         clr_tw;   // pulse timeout_clear at the end of this TW (0 = never)
        logic [1:0] exp_ct;
        int         exp_tw;
        int         exp_rlow;
        logic       exp_terr;
    } vec_t;

    vec_t exp_q[$];
    vec_t table_v[8];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(input logic [2:0] s, input logic m, input int lp,
                                input int clr, input logic [1:0] ct, input int tw,
                                input int rl, input logic te);
        vec_t v;
        v.status = s; v.mwe = m; v.lowp = lp; v.clr_tw = clr;
        v.exp_ct = ct; v.exp_tw = tw; v.exp_rlow = rl; v.exp_terr = te;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input logic p, input logic n);
        cpu_clock_posedge = p;
        cpu_clock_negedge = n;
        @(posedge clock);
        #1;
        cpu_clock_posedge = 1'b0;
        cpu_clock_negedge = 1'b0;
    endtask

    task automatic cpu_period();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
    endtask

    // One full bus cycle: passive lead-in, status held until T3 is seen, then passive.
    task automatic run_bus(input vec_t v, input string tag);
        vec_t       e;
        int         tw;
        int         rlow;
        int         moves;
        logic [1:0] ct_seen;
        logic       done;
        logic       rb;
        exp_q.push_back(v);
        mem_wait_enable = v.mwe;
        processor_status = 3'b111;
        peripheral_ready = 1'b1;
        cpu_period();
        processor_status = v.status;
        tw = 0; rlow = 0; moves = 0; ct_seen = v.exp_ct; done = 1'b0;
        for (int per = 0; per < 40 && !done; per++) begin
            timeout_clear = (v.clr_tw != 0) && (wait_active === 1'b1) && (tw == v.clr_tw);
            rb = ready;
            tick(1'b1, 1'b0);
            timeout_clear = 1'b0;
            if (ready !== rb) moves++;
            if (processor_status == 3'b111) begin
                done = 1'b1;
            end else begin
                if (cycle_type !== v.exp_ct && ct_seen === v.exp_ct) ct_seen = cycle_type;
                if (wait_active === 1'b1) tw++;
                else if (per >= 2) processor_status = 3'b111;
            end
            peripheral_ready = !(per >= 1 && per <= v.lowp);
            tick(1'b0, 1'b1);
            if (ready !== 1'b1) rlow++;
            rb = ready;
            tick(1'b0, 1'b0);
            if (ready !== rb) moves++;
        end
        peripheral_ready = 1'b1;
        e = exp_q.pop_front();
        check({tag, "_finished"}, 32'(done), 1);
        check({tag, "_ctype"}, 32'(ct_seen), 32'(e.exp_ct));
        check({tag, "_tw"}, tw, e.exp_tw);
        check({tag, "_ready_low"}, rlow, e.exp_rlow);
        check({tag, "_ready_neg_only"}, moves, 0);
        check({tag, "_idle_ctype"}, 32'(cycle_type), 0);
        check({tag, "_terr"}, 32'(timeout_error), 32'(e.exp_terr));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        table_v[0] = mk(3'b100, 1'b0, 0, 0, 2'b01, 0, 0, 1'b0);
        table_v[1] = mk(3'b101, 1'b1, 0, 0, 2'b01, 2, 2, 1'b0);
        table_v[2] = mk(3'b101, 1'b1, 6, 0, 2'b01, 6, 6, 1'b0);
        table_v[3] = mk(3'b110, 1'b0, 0, 0, 2'b01, 0, 0, 1'b0);
        table_v[4] = mk(3'b001, 1'b0, 0, 0, 2'b10, 1, 1, 1'b0);
        table_v[5] = mk(3'b001, 1'b0, 2, 0, 2'b10, 2, 2, 1'b0);
        table_v[6] = mk(3'b010, 1'b1, 0, 0, 2'b10, 1, 1, 1'b0);
        table_v[7] = mk(3'b101, 1'b0, 3, 0, 2'b01, 3, 3, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", 32'(ready), 1);
        check("rst_ctype", 32'(cycle_type), 0);
        check("rst_wait_active", 32'(wait_active), 0);
        check("rst_terr", 32'(timeout_error), 0);
        reset = 1'b0;
        tick(1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_bus(table_v[i], $sformatf("vec%0d", i));
        end

        // HALT starts no cycle; a later INTA does
        processor_status = 3'b111;
        cpu_period();
        processor_status = 3'b011;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            check("halt_ctype", 32'(cycle_type), 0);
            check("halt_wait_active", 32'(wait_active), 0);
            tick(1'b0, 1'b1);
            check("halt_ready", 32'(ready), 1);
            tick(1'b0, 1'b0);
        end
        run_bus(mk(3'b000, 1'b0, 0, 0, 2'b11, 1, 1, 1'b0), "inta");

        // Both strobes in one clock: the T1->T2 step must be visible to READY
        processor_status = 3'b111;
        cpu_period();
        processor_status = 3'b001;
        cpu_period();
        tick(1'b1, 1'b1);
        check("coinc_ready_t2", 32'(ready), 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("coinc_tw", 32'(wait_active), 1);
        tick(1'b0, 1'b1);
        check("coinc_tw_ready", 32'(ready), 1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("coinc_t3_wait_active", 32'(wait_active), 0);
        check("coinc_t3_ctype", 32'(cycle_type), 2);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        processor_status = 3'b111;
        cpu_period();
        check("coinc_idle_ctype", 32'(cycle_type), 0);

        // Passive status during T2 abandons the cycle
        processor_status = 3'b001;
        cpu_period();
        cpu_period();
        check("abort_t2_ready", 32'(ready), 0);
        processor_status = 3'b111;
        tick(1'b1, 1'b0);
        check("abort_ctype", 32'(cycle_type), 0);
        check("abort_wait_active", 32'(wait_active), 0);
        tick(1'b0, 1'b1);
        check("abort_ready", 32'(ready), 1);
        tick(1'b0, 1'b0);

        // Watchdog: expiry, sticky flag, clear, and clear coinciding with expiry
        run_bus(mk(3'b010, 1'b0, 30, 0, 2'b10, 8, 9, 1'b1), "tmo1");
        run_bus(mk(3'b100, 1'b0, 0, 0, 2'b01, 0, 0, 1'b1), "tmo_sticky");
        timeout_clear = 1'b1;
        tick(1'b0, 1'b0);
        timeout_clear = 1'b0;
        check("tmo_cleared", 32'(timeout_error), 0);
        run_bus(mk(3'b010, 1'b0, 30, 8, 2'b10, 8, 9, 1'b1), "tmo2_clear_same_clk");

        // Reset in the middle of an IO wait state
        processor_status = 3'b111;
        cpu_period();
        processor_status = 3'b001;
        cpu_period();
        peripheral_ready = 1'b0;
        cpu_period();
        tick(1'b1, 1'b0);
        check("rst_mid_in_tw", 32'(wait_active), 1);
        tick(1'b0, 1'b1);
        check("rst_mid_ready_low", 32'(ready), 0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_ready", 32'(ready), 1);
        check("rst_mid_ctype", 32'(cycle_type), 0);
        check("rst_mid_wait_active", 32'(wait_active), 0);
        check("rst_mid_terr", 32'(timeout_error), 0);
        tick(1'b0, 1'b0);
        reset = 1'b0;
        peripheral_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            check("rst_no_cycle_ctype", 32'(cycle_type), 0);
            check("rst_no_cycle_wait", 32'(wait_active), 0);
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b0);
        end
        run_bus(mk(3'b110, 1'b0, 0, 0, 2'b01, 0, 0, 1'b0), "memw_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
